seg7_result_decoder: RTL

- Receive-side decoder for the ALU's four-digit result display: consumes the HEX3..HEX0 segment buses and reconstructs the signed integer shown.
- Used as an on-chip checker and result-capture path, so test logic and downstream blocks see the displayed value directly, not the raw segments.
- Waits for the segment pattern to be stable, decodes each glyph, converts BCD to binary and applies the sign.
- Delivers the value over a valid/ready handshake.

---
 rtl/seg7_result_decoder.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/seg7_result_decoder.sv
// seg7_result_decoder: turns the ALU's four-digit seven-segment result display
// (HEX3 = sign, HEX2..HEX0 = hundreds/tens/units) back into a signed 9-bit
// integer and delivers it over a valid/ready handshake.
// Optional build macro SEG7_LEADING_BLANK_EN: accept blank leading digits
// (HEX2, and HEX1 when HEX2 is also blank) as zero. Undefined: blanks are illegal.
module seg7_result_decoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] HEX0,
  input  logic [6:0] HEX1,
  input  logic [6:0] HEX2,
  input  logic [6:0] HEX3,
  output logic [8:0] res_value,
  output logic       res_err,
  output logic       res_valid,
  input  logic       res_ready
);

`ifdef SEG7_LEADING_BLANK_EN
  localparam bit LEAD_BLANK = 1'b1;
`else
  localparam bit LEAD_BLANK = 1'b0;
`endif

  localparam logic [7:0] SC = 8'(STABLE_CYCLES);

  typedef enum logic [2:0] {IDLE, STABLE, CONV, SIGN, HOLD} state_t;

  // Returns {illegal, digit}; illegal glyphs decode as digit 0.
  function automatic logic [4:0] dec_glyph(input logic [6:0] g);
    case (g)
      7'h7E:   dec_glyph = {1'b0, 4'd0};
      7'h30:   dec_glyph = {1'b0, 4'd1};
      7'h6D:   dec_glyph = {1'b0, 4'd2};
      7'h79:   dec_glyph = {1'b0, 4'd3};
      7'h33:   dec_glyph = {1'b0, 4'd4};
      7'h5B:   dec_glyph = {1'b0, 4'd5};
      7'h5F:   dec_glyph = {1'b0, 4'd6};
      7'h70:   dec_glyph = {1'b0, 4'd7};
      7'h7F:   dec_glyph = {1'b0, 4'd8};
      7'h7B:   dec_glyph = {1'b0, 4'd9};
      default: dec_glyph = {1'b1, 4'd0};
    endcase
  endfunction

  state_t      state, state_n;
  logic [7:0]  cnt, cnt_n;
  logic [27:0] snap, prev, work, work_n, last, last_n;
  logic        last_vld, last_vld_n;
  logic [9:0]  acc, acc_n;
  logic        err, err_n;
  logic [1:0]  idx, idx_n;
  logic [8:0]  val_n;
  logic        rerr_n, rvld_n;
  logic [6:0]  g;
  logic [4:0]  d;
  logic        blank_ok, ovf;
  logic [7:0]  mag;

  // State and datapath registers; the snap/prev pair gives the registered
  // sample and the one before it for the stability comparison.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      snap      <= 28'd0;
      prev      <= 28'd0;
      work      <= 28'd0;
      last      <= 28'd0;
      last_vld  <= 1'b0;
      acc       <= 10'd0;
      err       <= 1'b0;
      idx       <= 2'd0;
      res_value <= 9'd0;
      res_err   <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      snap      <= {HEX3, HEX2, HEX1, HEX0};
      prev      <= snap;
      work      <= work_n;
      last      <= last_n;
      last_vld  <= last_vld_n;
      acc       <= acc_n;
      err       <= err_n;
      idx       <= idx_n;
      res_value <= val_n;
      res_err   <= rerr_n;
      res_valid <= rvld_n;
    end
  end

  // Next-state and datapath: stability counting, BCD accumulation, sign/range.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    work_n     = work;
    last_n     = last;
    last_vld_n = last_vld;
    acc_n      = acc;
    err_n      = err;
    idx_n      = idx;
    val_n      = res_value;
    rerr_n     = res_err;
    rvld_n     = res_valid;
    g          = 7'd0;
    d          = 5'd0;
    blank_ok   = 1'b0;
    ovf        = 1'b0;
    mag        = 8'd0;
    case (state)
      IDLE: begin
        state_n = STABLE;
        cnt_n   = 8'd1;
      end
      STABLE: begin
        if (snap == prev) cnt_n = (cnt >= SC) ? SC : cnt + 8'd1;
        else              cnt_n = 8'd1;
        // A stable pattern equal to the last delivered one stays parked here.
        if (cnt_n == SC && !(last_vld && snap == last)) begin
          work_n  = snap;
          acc_n   = 10'd0;
          err_n   = 1'b0;
          idx_n   = 2'd0;
          state_n = CONV;
        end
      end
      CONV: begin
        case (idx)
          2'd0: begin
            g        = work[20:14];
            blank_ok = LEAD_BLANK && (g == 7'd0);
          end
          2'd1: begin
            g        = work[13:7];
            blank_ok = LEAD_BLANK && (work[20:14] == 7'd0) && (g == 7'd0);
          end
          default: g = work[6:0];
        endcase
        d     = dec_glyph(g);
        acc_n = acc * 10'd10 + {6'd0, d[3:0]};
        if (d[4] && !blank_ok) err_n = 1'b1;
        if (idx == 2'd0 && work[27:21] != 7'h00 && work[27:21] != 7'h01) err_n = 1'b1;
        if (idx == 2'd2) state_n = SIGN;
        else             idx_n   = idx + 2'd1;
      end
      SIGN: begin
        ovf = (acc > 10'd255);
        mag = acc[7:0];
        if (err || ovf) begin
          val_n  = 9'd0;
          rerr_n = 1'b1;
        end else begin
          val_n  = work[21] ? 9'd0 - {1'b0, mag} : {1'b0, mag};
          rerr_n = 1'b0;
        end
        rvld_n  = 1'b1;
        state_n = HOLD;
      end
      HOLD: begin
        if (res_ready) begin
          rvld_n     = 1'b0;
          last_n     = work;
          last_vld_n = 1'b1;
          cnt_n      = 8'd1;
          state_n    = STABLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
